instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 38 +++
 rtl/instr_encoder_if.sv | 37 +++
 rtl/instr_encoder_imm_pack.sv | 75 +++++++
 rtl/instr_encoder.sv | 104 ++++++++++
 tb/tb_instr_encoder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared decode constants for the instruction encoder and core controller.
// Holds the RV32I opcode values, the request-kind encoding, the encoder FSM
// state type and a signed range helper used by the legality checks.
package instr_encoder_pkg;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_U    = 7'b0110111;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   typedef enum logic [2:0] {
      KIND_R    = 3'd0,
      KIND_I    = 3'd1,
      KIND_U    = 3'd2,
      KIND_LW   = 3'd3,
      KIND_SW   = 3'd4,
      KIND_BR   = 3'd5,
      KIND_JAL  = 3'd6,
      KIND_JALR = 3'd7
   } req_kind_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } enc_state_t;

   // Inclusive signed range test on a 32-bit immediate.
   function automatic logic in_range(input logic signed [31:0] v,
                                     input logic signed [31:0] lo,
                                     input logic signed [31:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus of the encoder.
//   master : drives requests, set_base/base and wr_ready (controller / bench)
//   slave  : the encoder; returns req_ready, the write port, err and err_count
interface instr_encoder_if;
   import instr_encoder_pkg::*;

   logic        req_valid;
   logic        req_ready;
   req_kind_t   req_kind;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        set_base;
   logic [31:0] base;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        err;
   logic [7:0]  err_count;

   modport master (
      output req_valid, req_kind, funct3, funct7b5, rd, rs1, rs2, imm,
             set_base, base, wr_ready,
      input  req_ready, wr_valid, wr_addr, wr_data, err, err_count
   );

   modport slave (
      input  req_valid, req_kind, funct3, funct7b5, rd, rs1, rs2, imm,
             set_base, base, wr_ready,
      output req_ready, wr_valid, wr_addr, wr_data, err, err_count
   );

endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational RV32I word packer with legality check.
//   kind, funct3, funct7b5, rd, rs1, rs2, imm : request fields
//   word  : packed 32-bit instruction
//   legal : request passes the immediate range/alignment checks
module instr_imm_pack
   import instr_encoder_pkg::*;
(
   input  req_kind_t   kind,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        legal
);

   logic signed [31:0] simm;
   logic [6:0]         funct7;
   logic               is_shift;

   assign simm     = imm;
   assign funct7   = {1'b0, funct7b5, 5'b00000};
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   always_comb begin
      word  = '0;
      legal = 1'b0;
      case (kind)
         KIND_R: begin
            word  = {funct7, rs2, rs1, funct3, rd, OP_R};
            legal = 1'b1;
         end
         KIND_I: begin
            if (is_shift) begin
               word  = {funct7, imm[4:0], rs1, funct3, rd, OP_I};
               legal = (imm[31:5] == '0);
            end else begin
               word  = {imm[11:0], rs1, funct3, rd, OP_I};
               legal = in_range(simm, -32'sd2048, 32'sd2047);
            end
         end
         KIND_U: begin
            word  = {imm[31:12], rd, OP_U};
            legal = (imm[11:0] == '0);
         end
         KIND_LW: begin
            word  = {imm[11:0], rs1, funct3, rd, OP_LW};
            legal = in_range(simm, -32'sd2048, 32'sd2047);
         end
         KIND_SW: begin
            word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_SW};
            legal = in_range(simm, -32'sd2048, 32'sd2047);
         end
         KIND_BR: begin
            word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BR};
            legal = in_range(simm, -32'sd4096, 32'sd4094) && !imm[0];
         end
         KIND_JAL: begin
            word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            legal = in_range(simm, -32'sd1048576, 32'sd1048574) && !imm[0];
         end
         KIND_JALR: begin
            word  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            legal = in_range(simm, -32'sd2048, 32'sd2047);
         end
         default: begin
            word  = '0;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts encode requests, writes the packed word to
// instruction memory at an auto-incrementing address, and counts rejects.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : request / write / error bus (slave side)
module instr_encoder
   import instr_encoder_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   instr_encoder_if.slave   bus
);

   enc_state_t  state;
   logic        ready_q;
   logic        valid_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic        err_q;
   logic [7:0]  err_count_q;
   logic        base_pend;
   logic [31:0] base_next;

   logic [31:0] word;
   logic        legal;
   logic [31:0] base_al;

   assign base_al = bus.base & ~32'h0000_0003;

   instr_imm_pack u_pack (
      .kind     (bus.req_kind),
      .funct3   (bus.funct3),
      .funct7b5 (bus.funct7b5),
      .rd       (bus.rd),
      .rs1      (bus.rs1),
      .rs2      (bus.rs2),
      .imm      (bus.imm),
      .word     (word),
      .legal    (legal)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         ready_q     <= 1'b1;
         valid_q     <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
         err_count_q <= '0;
         base_pend   <= 1'b0;
         base_next   <= '0;
      end else begin
         err_q <= 1'b0;
         case (state)
            S_IDLE: begin
               // A same-cycle request lands at the freshly loaded base.
               if (bus.set_base)
                  addr_q <= base_al;
               if (bus.req_valid) begin
                  if (legal) begin
                     data_q  <= word;
                     valid_q <= 1'b1;
                     ready_q <= 1'b0;
                     state   <= S_HOLD;
                  end else begin
                     err_q <= 1'b1;
                     if (err_count_q != 8'hFF)
                        err_count_q <= err_count_q + 8'd1;
                  end
               end
            end
            S_HOLD: begin
               // The pending address stays put; a base set while holding is
               // parked and replaces the +4 step once the word is taken.
               if (bus.wr_ready) begin
                  valid_q   <= 1'b0;
                  ready_q   <= 1'b1;
                  state     <= S_IDLE;
                  base_pend <= 1'b0;
                  if (bus.set_base)
                     addr_q <= base_al;
                  else if (base_pend)
                     addr_q <= base_next;
                  else
                     addr_q <= addr_q + 32'd4;
               end else if (bus.set_base) begin
                  base_pend <= 1'b1;
                  base_next <= base_al;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.wr_valid  = valid_q;
   assign bus.wr_addr   = addr_q;
   assign bus.wr_data   = data_q;
   assign bus.err       = err_q;
   assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed words.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   instr_encoder_if bus ();

   instr_encoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input req_kind_t k, input logic [2:0] f3, input logic f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im);
      bus.req_kind = k;
      bus.funct3   = f3;
      bus.funct7b5 = f7;
      bus.rd       = d;
      bus.rs1      = s1;
      bus.rs2      = s2;
      bus.imm      = im;
   endtask

   task automatic send(input req_kind_t k, input logic [2:0] f3, input logic f7,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
      drive(k, f3, f7, d, s1, s2, im);
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic expect_word(input string tag, input logic [31:0] a, input logic [31:0] d);
      chk({tag, "_valid"}, {31'd0, bus.wr_valid}, 32'd1);
      chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd0);
      chk({tag, "_addr"}, bus.wr_addr, a);
      chk({tag, "_data"}, bus.wr_data, d);
   endtask

   task automatic take(input string tag, input logic [31:0] next_addr);
      bus.wr_ready = 1'b1;
      tick();
      bus.wr_ready = 1'b0;
      chk({tag, "_done_valid"}, {31'd0, bus.wr_valid}, 32'd0);
      chk({tag, "_done_addr"}, bus.wr_addr, next_addr);
   endtask

   task automatic reject(input string tag, input logic [7:0] cnt);
      chk({tag, "_novalid"}, {31'd0, bus.wr_valid}, 32'd0);
      chk({tag, "_err"}, {31'd0, bus.err}, 32'd1);
      chk({tag, "_cnt"}, {24'd0, bus.err_count}, {24'd0, cnt});
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.set_base  = 1'b0;
      bus.base      = '0;
      bus.wr_ready  = 1'b0;
      drive(KIND_R, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);

      tick();
      tick();
      chk("rst_valid", {31'd0, bus.wr_valid}, 32'd0);
      chk("rst_addr", bus.wr_addr, 32'd0);
      chk("rst_data", bus.wr_data, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_cnt", {24'd0, bus.err_count}, 32'd0);
      chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
      reset = 1'b0;
      tick();

      // addi x1,x0,5
      send(KIND_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
      expect_word("addi", 32'h0, 32'h00500093);
      take("addi", 32'h4);

      // sw x2,8(x1) with set_base 0 in the same cycle
      bus.set_base = 1'b1;
      bus.base     = 32'h0;
      send(KIND_SW, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
      bus.set_base = 1'b0;
      expect_word("sw", 32'h0, 32'h0020A423);
      take("sw", 32'h4);

      // jal x1,8
      send(KIND_JAL, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
      expect_word("jal", 32'h4, 32'h008000EF);
      take("jal", 32'h8);

      // lui x5,0x12345
      send(KIND_U, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
      expect_word("lui", 32'h8, 32'h123452B7);
      take("lui", 32'hC);

      send(KIND_U, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345001);
      reject("lui_bad", 8'd1);
      chk("lui_bad_ready", {31'd0, bus.req_ready}, 32'd1);
      tick();
      chk("err_pulse_end", {31'd0, bus.err}, 32'd0);
      chk("lui_bad_addr", bus.wr_addr, 32'hC);

      // sub x3,x1,x2 with a 3-cycle stall and set_base 0x103 during it
      send(KIND_R, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
      expect_word("sub", 32'hC, 32'h402081B3);
      bus.set_base = 1'b1;
      bus.base     = 32'h103;
      tick();
      bus.set_base = 1'b0;
      expect_word("stall1", 32'hC, 32'h402081B3);
      tick();
      expect_word("stall2", 32'hC, 32'h402081B3);
      tick();
      expect_word("stall3", 32'hC, 32'h402081B3);
      take("sub", 32'h100);

      // srai x4,x1,3; set_base 0x200 coincides with the handshake
      send(KIND_I, 3'b101, 1'b1, 5'd4, 5'd1, 5'd0, 32'd3);
      expect_word("srai", 32'h100, 32'h4030D213);
      bus.set_base = 1'b1;
      bus.base     = 32'h200;
      take("srai", 32'h200);
      bus.set_base = 1'b0;

      // beq x1,x2,-4
      send(KIND_BR, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
      expect_word("beq", 32'h200, 32'hFE208EE3);
      take("beq", 32'h204);

      // jalr x0,0(x1) with funct3 port 3 -> forced to 000
      send(KIND_JALR, 3'b011, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0);
      expect_word("jalr", 32'h204, 32'h00008067);
      take("jalr", 32'h208);

      // lw x6,-4(x2)
      send(KIND_LW, 3'b010, 1'b0, 5'd6, 5'd2, 5'd0, 32'hFFFF_FFFC);
      expect_word("lw", 32'h208, 32'hFFC12303);
      take("lw", 32'h20C);

      // illegal immediates
      send(KIND_BR, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
      reject("br_odd", 8'd2);
      send(KIND_I, 3'b101, 1'b1, 5'd4, 5'd1, 5'd0, 32'd32);
      reject("sh_32", 8'd3);
      send(KIND_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
      reject("addi_2048", 8'd4);
      send(KIND_JAL, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
      reject("jal_odd", 8'd5);

      // boundary legal: addi x1,x0,-2048
      send(KIND_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
      expect_word("addi_min", 32'h20C, 32'h80000093);
      take("addi_min", 32'h210);

      // 256 back-to-back rejects saturate the counter
      drive(KIND_BR, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
      bus.req_valid = 1'b1;
      for (int i = 0; i < 256; i++) tick();
      bus.req_valid = 1'b0;
      reject("sat", 8'd255);
      tick();
      chk("sat_hold", {24'd0, bus.err_count}, 32'd255);

      // set_base alone in IDLE, then address wraps past 2^32
      bus.set_base = 1'b1;
      bus.base     = 32'hFFFF_FFFE;
      tick();
      bus.set_base = 1'b0;
      chk("base_load", bus.wr_addr, 32'hFFFF_FFFC);
      send(KIND_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
      expect_word("wrap", 32'hFFFF_FFFC, 32'h00500093);
      take("wrap", 32'h0);

      // reset asserted mid-cycle during HOLD discards the word
      send(KIND_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
      expect_word("pre_rst", 32'h0, 32'h00500093);
      bus.wr_ready = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("hold_rst_valid", {31'd0, bus.wr_valid}, 32'd0);
      chk("hold_rst_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("hold_rst_cnt", {24'd0, bus.err_count}, 32'd0);
      tick();
      bus.wr_ready = 1'b0;
      reset = 1'b0;
      tick();
      chk("post_rst_valid", {31'd0, bus.wr_valid}, 32'd0);
      chk("post_rst_addr", bus.wr_addr, 32'h0);
      chk("post_rst_data", bus.wr_data, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
